uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver that pairs with the existing transmitter; it deserialises 8N1 frames arriving on an asynchronous serial line.
- It delivers one byte per valid frame with a single-cycle done strobe.
- It flags framing errors and rejects start-bit glitches shorter than half a bit.
- It sits between the board RX pin and the command parser that drives the DDS control registers.

Parameters:
- SYS_CLK_FRE, 50_000_000: system clock frequency in Hz.
- BPS, 9_600: baud rate.
- BPS_CNT, SYS_CLK_FRE/BPS: clocks per bit. Must be at least 8. The counter is 16 bits, so BPS_CNT must be at most 65535.

Ports:
- sys_clk, input, 1: system clock.
- sys_rst_n, input, 1: synchronous reset.
- uart_rxd, input, 1: serial line, asynchronous to sys_clk, idle high.
- uart_data, output, 8: last received byte, LSB first on the wire.
- uart_rx_done, output, 1: one-cycle pulse when uart_data is updated with a valid frame.
- uart_rx_err, output, 1: one-cycle pulse when a frame has a bad stop bit.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is synchronous and active-high: reset is applied when sys_rst_n == 1 at a sys_clk edge.
- Reset values:
  - uart_data = 8'h00, uart_rx_done = 0, uart_rx_err = 0.
  - State = IDLE, clk_cnt = 0, bit_cnt = 0.
  - Synchroniser flops rx_d0, rx_d1, rx_d2 = 1.
- Synchroniser: uart_rxd -> rx_d0 -> rx_d1 (metastability pair) -> rx_d2 (edge-detect history). Falling edge = rx_d2 & ~rx_d1. All sampling uses rx_d1.
- State IDLE:
  - clk_cnt = 0, bit_cnt = 0.
  - On a falling edge: go to START with clk_cnt = 0.
  - A line held low with no edge (break) never triggers a frame.
- State START: clk_cnt counts up by 1 per cycle. When clk_cnt == BPS_CNT/2 (integer division), sample rx_d1:
  - rx_d1 == 1: glitch. Return to IDLE with no outputs.
  - rx_d1 == 0: go to DATA, clk_cnt = 0, bit_cnt = 0. From this point, samples fall at mid-bit every BPS_CNT cycles.
- State DATA:
  - clk_cnt counts 0..BPS_CNT-1 and wraps to 0.
  - When clk_cnt == BPS_CNT-1, shift rx_d1 into shift_reg[bit_cnt] and increment bit_cnt.
  - After bit_cnt reaches 8, go to STOP with clk_cnt = 0.
- State STOP: when clk_cnt == BPS_CNT-1, sample rx_d1:
  - rx_d1 == 1: on the next edge, uart_data <= shift_reg and uart_rx_done = 1 for exactly one cycle.
  - rx_d1 == 0: uart_rx_err = 1 for one cycle. uart_data is held unchanged and uart_rx_done stays 0.
  - In both cases return to IDLE. This is mid stop bit, so back-to-back frames resynchronise on the next start edge.
- Latency: uart_rx_done is high exactly 3 + BPS_CNT/2 + 9*BPS_CNT + 1 cycles after the first sys_clk edge that samples uart_rxd low. For BPS_CNT = 10 that is 99 cycles.
- Outputs: uart_data is stable between done pulses. uart_rx_done and uart_rx_err are mutually exclusive.
- Reset mid-frame: takes effect next edge. Partial data is discarded, no pulse is emitted, and uart_data returns to 0.
- A falling edge while in START, DATA or STOP is ignored; there is no restart mid-frame.
- Baud tolerance: correct reception with ±3% total clock mismatch, since sampling is at mid-bit.

Decomposition:
- Shared include uart_defs.vh:
  - State encodings IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3.
  - DATA_BITS = 8.
  - Default SYS_CLK_FRE and BPS values, to be shared with the transmitter.
- One natural sub-module: uart_sync, a 3-flop synchroniser with rx_d1 and fall outputs and reset value 1. It is reusable by other async inputs.
- The FSM, counters and shift register stay in uart_rx.

Test Plan:
All scenarios use SYS_CLK_FRE = 1_000_000 and BPS = 100_000, so BPS_CNT = 10.
1. Reset, then idle line for 200 cycles -> uart_data = 8'h00 and no pulses.
2. Send 8'hA5 as an ideal 8N1 frame -> one uart_rx_done pulse 99 cycles after the start edge; uart_data = 8'hA5; uart_rx_err stays 0.
3. Back-to-back bytes 8'h00, 8'hFF, 8'h3C with no idle gap -> three done pulses in order with matching data.
4. Low glitch of 3 cycles on uart_rxd -> no done pulse and no error pulse. A valid frame 8'h5A sent 20 cycles later is received correctly.
5. Frame 8'h81 with stop bit driven 0 -> single uart_rx_err pulse; uart_data keeps its previous value; no done pulse. With the line then held low for 50 cycles, no further pulses occur.
6. Assert sys_rst_n for 1 cycle during data bit 4 of a frame -> no pulses and uart_data = 0. The next full frame 8'hC3 is received correctly. Repeat scenario 2 with BPS_CNT = 10.3 timing skew (±3%) -> data still correct.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receive-path types and defaults
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS       = 8;
    localparam int DEF_SYS_CLK_FRE = 50_000_000;
    localparam int DEF_BPS         = 9_600;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - 3-flop synchroniser with falling-edge detect, resets to 1
module uart_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic d0_q;
    logic d1_q;
    logic d2_q;

    // d0/d1 resolve metastability; d2 is one cycle of history for edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d0_q <= 1'b1;
            d1_q <= 1'b1;
            d2_q <= 1'b1;
        end else begin
            d0_q <= async_i;
            d1_q <= d0_q;
            d2_q <= d1_q;
        end
    end

    assign sync_o = d1_q;
    assign fall_o = d2_q & ~d1_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with glitch rejection and framing-error strobe
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int SYS_CLK_FRE = DEF_SYS_CLK_FRE,
    parameter int BPS         = DEF_BPS
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_rx_done,
    output logic       uart_rx_err
);

    localparam int          BPS_CNT  = SYS_CLK_FRE / BPS;
    localparam logic [15:0] CNT_MAX  = 16'(BPS_CNT - 1);
    localparam logic [15:0] CNT_HALF = 16'(BPS_CNT / 2);
    localparam logic [3:0]  BITS_END = 4'(DATA_BITS);

    logic rx_sync;
    logic rx_fall;

    uart_state_e state_q, state_d;
    logic [15:0] clk_cnt_q, clk_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    uart_sync u_sync (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst_n),
        .async_i (uart_rxd),
        .sync_o  (rx_sync),
        .fall_o  (rx_fall)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst_n) begin
            state_q   <= IDLE;
            clk_cnt_q <= 16'd0;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Frame sequencing: verify start at half-bit, then sample every full bit period
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                clk_cnt_d = 16'd0;
                bit_cnt_d = 4'd0;
                // Only an edge starts a frame, so a held-low line (break) is ignored
                if (rx_fall) begin
                    state_d = START;
                end
            end

            START: begin
                if (clk_cnt_q == CNT_HALF) begin
                    clk_cnt_d = 16'd0;
                    bit_cnt_d = 4'd0;
                    // Line back high at mid start bit means it was a glitch
                    state_d   = rx_sync ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_cnt_q == BITS_END) begin
                    state_d   = STOP;
                    clk_cnt_d = 16'd0;
                end else if (clk_cnt_q == CNT_MAX) begin
                    shift_d[bit_cnt_q[2:0]] = rx_sync;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    clk_cnt_d = 16'd0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end

            STOP: begin
                if (clk_cnt_q == CNT_MAX) begin
                    // Leave mid stop bit so the next start edge is never missed
                    state_d   = IDLE;
                    clk_cnt_d = 16'd0;
                    if (rx_sync) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign uart_data    = data_q;
    assign uart_rx_done = done_q;
    assign uart_rx_err  = err_q;

endmodule
